// File: rtl/rv32i_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the rv32i
// memory-stage load/store sequencer.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                             input logic [31:0] rs2);
    case (funct3[1:0])
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_ld_align.sv
// Selects the addressed byte/halfword of a load word and sign- or
// zero-extends it according to funct3.
module rv32i_ld_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_ctrl.sv
// Memory-stage load/store sequencer: decodes the instruction, runs one
// req/ack bus transaction with stall, and returns extended load data.
module rv32i_mem_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err_align,
  output logic        err_timeout
);

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  mem_state_t  state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] ld_ext;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_mem, legal, aligned;
  logic       accept, reject, ack_hit, timeout_hit;

  assign opcode = iw_in[6:0];
  assign funct3 = iw_in[14:12];

  logic unused_iw;
  assign unused_iw = ^{iw_in[31:15], iw_in[11:7]};

  always_comb begin
    legal = 1'b0;
    if (opcode == OP_LOAD)
      legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else if (opcode == OP_STORE)
      legal = funct3 inside {F3_B, F3_H, F3_W};
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   aligned = ~alu_in[0];
      2'b10:   aligned = (alu_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Gated by reset so stall drops the moment reset asserts, even with valid_in high.
  assign accept      = reset && (state == IDLE) && valid_in && is_mem && legal && aligned;
  assign reject      = (state == IDLE) && valid_in && is_mem && !(legal && aligned);
  assign ack_hit     = (state == BUS) && mem_ack;
  assign timeout_hit = (state == BUS) && !mem_ack && (cnt == CNT_LIMIT);

  rv32i_ld_align u_ld_align (
    .rdata  (mem_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (ld_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        stall = 1'b1;
        if (ack_hit || timeout_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      ld_valid    <= 1'b0;
      ld_data     <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      mem_req     <= (state_nxt == BUS);
      ld_valid    <= 1'b0;
      err_align   <= reject;
      err_timeout <= timeout_hit;

      if (accept) begin
        mem_addr  <= {alu_in[31:2], 2'b00};
        mem_be    <= byte_enables(funct3, alu_in[1:0]);
        mem_wdata <= store_data(funct3, rs2_in);
        mem_we    <= (opcode == OP_STORE);
        f3_q      <= funct3;
        lo_q      <= alu_in[1:0];
        cnt       <= '0;
      end else if (state == BUS) begin
        cnt <= (ack_hit || timeout_hit) ? 16'd0 : cnt + 16'd1;
      end

      if (ack_hit && !mem_we) begin
        ld_data  <= ld_ext;
        ld_valid <= 1'b1;
      end else if (timeout_hit) begin
        ld_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_ctrl.sv
// Directed testbench for rv32i_mem_ctrl with hand-computed expected values.
module tb_rv32i_mem_ctrl;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] iw_in, alu_in, rs2_in;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err_align, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .iw_in       (iw_in),
    .alu_in      (alu_in),
    .rs2_in      (rs2_in),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .err_align   (err_align),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic present(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2);
    valid_in = 1'b1;
    iw_in    = mk_iw(op, f3);
    alu_in   = addr;
    rs2_in   = rs2;
  endtask

  // Accepted access; ack arrives after 'waits' idle BUS cycles.
  task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input int waits,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    logic is_ld;
    is_ld = (op == OP_LD);
    present(op, f3, addr, rs2);
    #1;
    check({tag, ".stall_acc"}, stall, 1'b1);
    check({tag, ".req_acc"}, mem_req, 1'b0);
    tick();
    for (int i = 0; i < waits; i++) begin
      check({tag, ".req_wait"}, mem_req, 1'b1);
      check({tag, ".stall_wait"}, stall, 1'b1);
      tick();
    end
    check({tag, ".req"}, mem_req, 1'b1);
    check({tag, ".stall_bus"}, stall, 1'b1);
    check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, ".be"}, mem_be, exp_be);
    check({tag, ".we"}, mem_we, !is_ld);
    check({tag, ".wdata"}, mem_wdata, exp_wdata);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".ld_valid"}, ld_valid, is_ld);
    if (is_ld) check({tag, ".ld_data"}, ld_data, exp_ld);
    check({tag, ".stall_resp"}, stall, 1'b0);
    check({tag, ".req_resp"}, mem_req, 1'b0);
    check({tag, ".no_tmo"}, err_timeout, 1'b0);
    valid_in = 1'b0;
    tick();
    check({tag, ".ld_valid_end"}, ld_valid, 1'b0);
  endtask

  task automatic run_bad(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic exp_err);
    present(op, f3, addr, 32'h0);
    #1;
    check({tag, ".stall"}, stall, 1'b0);
    tick();
    valid_in = 1'b0;
    check({tag, ".req"}, mem_req, 1'b0);
    check({tag, ".err_align"}, err_align, exp_err);
    tick();
    check({tag, ".err_align_end"}, err_align, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; iw_in = 32'h0; alu_in = 32'h0;
    rs2_in = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst.stall", stall, 1'b0);
    check("rst.req", mem_req, 1'b0);
    check("rst.we", mem_we, 1'b0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.be", mem_be, 4'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.ld_valid", ld_valid, 1'b0);
    check("rst.ld_data", ld_data, 32'h0);
    check("rst.err", {err_align, err_timeout}, 2'b00);
    reset = 1'b1;
    tick();

    run_txn("lw",   OP_LD, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_txn("lb",   OP_LD, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_txn("lbu",  OP_LD, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080);
    run_txn("sh",   OP_ST, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    run_txn("lh",   OP_LD, 3'b001, 32'h102, 32'h0, 1, 32'h80017FFF, 4'b1100, 32'h0, 32'hFFFF8001);
    run_txn("lhu",  OP_LD, 3'b101, 32'h100, 32'h0, 0, 32'h1234F00F, 4'b0011, 32'h0, 32'h0000F00F);
    run_txn("sb",   OP_ST, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_txn("sw",   OP_ST, 3'b010, 32'h400, 32'hCAFEF00D, 2, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
    run_txn("lb_pos", OP_LD, 3'b000, 32'h101, 32'h0, 0, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F);
    run_txn("lw_ack4", OP_LD, 3'b010, 32'h600, 32'h0, 3, 32'h13579BDF, 4'b1111, 32'h0, 32'h13579BDF);

    run_bad("lw_mis",  OP_LD,  3'b010, 32'h101, 1'b1);
    run_bad("ld_f3_3", OP_LD,  3'b011, 32'h100, 1'b1);
    run_bad("lh_mis",  OP_LD,  3'b001, 32'h101, 1'b1);
    run_bad("st_f3_4", OP_ST,  3'b100, 32'h100, 1'b1);
    run_bad("alu_op",  OP_ALU, 3'b010, 32'h101, 1'b0);

    // Timeout: no ack for four BUS cycles.
    present(OP_LD, 3'b010, 32'h500, 32'h0);
    #1;
    check("tmo.stall_acc", stall, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("tmo.req", mem_req, 1'b1);
      check("tmo.stall", stall, 1'b1);
      check("tmo.no_err_yet", err_timeout, 1'b0);
      tick();
    end
    check("tmo.req_drop", mem_req, 1'b0);
    check("tmo.err", err_timeout, 1'b1);
    check("tmo.ld_valid", ld_valid, 1'b0);
    check("tmo.ld_data", ld_data, 32'h0);
    check("tmo.stall_rel", stall, 1'b0);
    valid_in = 1'b0;
    tick();
    check("tmo.err_end", err_timeout, 1'b0);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stray.ld_valid", ld_valid, 1'b0);
    check("stray.req", mem_req, 1'b0);

    // Reset in the middle of BUS.
    present(OP_LD, 3'b010, 32'h700, 32'h0);
    tick();
    check("rbus.req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rbus.req_drop", mem_req, 1'b0);
    check("rbus.stall_drop", stall, 1'b0);
    check("rbus.be_clr", mem_be, 4'h0);
    check("rbus.no_err", {err_align, err_timeout}, 2'b00);
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    check("rbus.idle_req", mem_req, 1'b0);
    check("rbus.idle_err", {err_align, err_timeout}, 2'b00);
    run_txn("lw_post", OP_LD, 3'b010, 32'h800, 32'h0, 0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_ctrl.md
# rv32i_mem_ctrl

Load/store sequencer for the rv32i memory stage. It decodes the instruction word held in the memory stage and, for loads and stores, runs a req/ack transaction on the data-memory bus with the correct byte enables and store-data replication. While the transaction is outstanding it stalls the pipeline, then returns sign- or zero-extended load data toward writeback. Misaligned or illegal accesses and bus timeouts are flagged without hanging the pipeline.

## Interface
- TIMEOUT, 255: bus cycles without `mem_ack` before a transaction is aborted; range 1..65535.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  memory-stage instruction is valid.
- iw_in  in  32  instruction word; opcode iw_in[6:0], funct3 iw_in[14:12].
- alu_in  in  32  effective address from exTop.
- rs2_in  in  32  store data.
- stall  out  1  hold upstream pipeline registers.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  word address {alu_in[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  replicated store data.
- mem_ack  in  1  single-cycle bus completion.
- mem_rdata  in  32  load word, valid with mem_ack.
- ld_valid  out  1  one-cycle pulse, load data ready.
- ld_data  out  32  extended load result.
- err_align  out  1  one-cycle pulse, misaligned or illegal funct3.
- err_timeout  out  1  one-cycle pulse, bus timeout.

## Operation
- Load is opcode 7'b0000011; store is opcode 7'b0100011. All other opcodes pass through: no stall and no bus activity.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3 values: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Alignment rules:
  - Halfword requires alu_in[0]=0.
  - Word requires alu_in[1:0]=00.
  - A violation or illegal funct3 gives no bus access, stall=0, and err_align pulses the next cycle.
- Byte enables:
  - Byte access: mem_be = 4'b0001 << alu_in[1:0].
  - Halfword access: alu_in[1] ? 4'b1100 : 4'b0011.
  - Word access: 4'b1111.
- Store data: mem_wdata = {4{rs2[7:0]}} for bytes, {2{rs2[15:0]}} for halfwords, rs2 for words.
- Load data: the byte or halfword is selected by the latched address bits. Funct3 000/001 sign-extend, 100/101 zero-extend.
- State machine IDLE, BUS, RESP:
  - IDLE: on valid_in with a legal, aligned load or store, assert stall combinationally. Register the address, be, wdata, we and funct3, then go to BUS.
  - BUS: mem_req=1 with all bus outputs held stable. The timeout counter increments each cycle. On mem_ack, latch mem_rdata and go to RESP. When the counter reaches TIMEOUT-1 with no ack, drop the request, pulse err_timeout and go to RESP with ld_data=0 and no ld_valid.
  - RESP: stall=0, ld_valid pulses (loads only), then go to IDLE. A new operation may be accepted from IDLE on the following cycle.
- An ack in the same cycle as the timeout limit wins: it is a normal completion.
- mem_ack outside BUS is ignored.
- Reset asserted mid-transaction aborts immediately and drops mem_req. No error is flagged.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - stall, mem_req, mem_we, ld_valid, err_align, err_timeout = 0.
  - mem_addr, mem_be, mem_wdata, ld_data = 0.
- Minimum transaction (ack in first BUS cycle):
  - cycle 0 is accept with stall=1.
  - cycle 1 is BUS with mem_req=1, mem_ack=1.
  - cycle 2 is RESP with ld_valid=1 and stall=0.
- Load-to-use latency is 2 cycles plus the number of ack wait cycles.
- The stall=1 window runs from the accept cycle through the last BUS cycle, inclusive.
- All outputs except stall are registered.

## Structure
- Package rv32i_pkg holds:
  - opcode constants OP_LOAD and OP_STORE;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum mem_state_t {IDLE, BUS, RESP}.
- Sub-module rv32i_ld_align is combinational: it takes rdata, addr[1:0] and funct3, and outputs the extended data.
- FSM, counter and bus registers live in the top module.

## Test plan
- LW, alu_in=0x100, ack in first BUS cycle, rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, stall for 2 cycles, ld_valid with ld_data=0xDEADBEEF.
- LB at 0x103, rdata=0x80xxxxxx -> mem_be=1000, ld_data=0xFFFFFF80. LBU at the same address -> ld_data=0x00000080.
- SH at 0x202, rs2=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, no ld_valid.
- LW at 0x101 -> no mem_req, stall=0, err_align pulses one cycle later. The same pulse occurs for load funct3=011.
- TIMEOUT=4, no ack -> mem_req held 4 cycles then dropped, err_timeout pulses, stall releases. Ack on the 4th cycle instead -> normal completion with no error.
- Reset pulled low during BUS -> mem_req and stall go to 0 immediately. After release, a new LW completes normally.
